hash_control_unit: RTL and testbench

Control FSM that drives the byte-hash datapath (`Operative_module`) from an upstream byte stream. It accepts message bytes over a valid/ready handshake and issues the datapath strobes: `start`, `validate_input` (c), `switch_operation` (e), `validate_R_h` (f) and round index `R_i`. It sequences one load cycle plus ROUNDS digest rounds per byte, then ROUNDS finalization rounds, and signals digest completion. It sits between the host-side byte source and the datapath, and is the initiator of the datapath's control interface.

---
 rtl/hash_control_unit_if.sv | 34 +++
 rtl/hash_control_unit.sv | 144 ++++++++++++++
 tb/tb_hash_control_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_control_unit_if.sv
// Byte-stream handshake plus datapath control strobes of the hash control unit.
// master: the control unit; slave: the byte source, host and datapath side.
interface hash_control_unit_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RI_W   = 3;

  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              case_R_c_zero;
  logic              hash_start;
  logic [DATA_W-1:0] B;
  logic              validate_input;
  logic              switch_operation;
  logic              validate_R_h;
  logic [RI_W-1:0]   R_i;
  logic              busy;
  logic              digest_valid;
  logic              error;

  modport master (
    input  start, in_data, in_valid, in_last, case_R_c_zero,
    output in_ready, hash_start, B, validate_input, switch_operation,
           validate_R_h, R_i, busy, digest_valid, error
  );

  modport slave (
    output start, in_data, in_valid, in_last, case_R_c_zero,
    input  in_ready, hash_start, B, validate_input, switch_operation,
           validate_R_h, R_i, busy, digest_valid, error
  );
endinterface

// File: rtl/hash_control_unit.sv
// Control FSM sequencing one load plus ROUNDS digest rounds per byte, then
// ROUNDS finalization rounds, for the byte-hash datapath.
module hash_control_unit #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic                 clock,
  input  logic                 rstn,
  hash_control_unit_if.master  bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RI_W   = 3;
  localparam logic [RI_W-1:0] LAST_RND = RI_W'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT, S_LOAD, S_ROUND, S_FIN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic [RI_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              rdy_q, rdy_d;
  logic              hs_q, hs_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              vi_q, vi_d;
  logic              so_q, so_d;
  logic              vrh_q, vrh_d;
  logic [RI_W-1:0]   ri_q, ri_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;

  // State, working registers and output registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      hs_q    <= 1'b0;
      b_q     <= '0;
      vi_q    <= 1'b0;
      so_q    <= 1'b0;
      vrh_q   <= 1'b0;
      ri_q    <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      hs_q    <= hs_d;
      b_q     <= b_d;
      vi_q    <= vi_d;
      so_q    <= so_d;
      vrh_q   <= vrh_d;
      ri_q    <= ri_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register
  // in step with the state they belong to.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.in_valid) begin
          if (bus.case_R_c_zero) begin
            byte_d  = bus.in_data;
            last_d  = bus.in_last;
            state_d = S_LOAD;
          end else begin
            // Datapath byte counter saturated: drop the byte and end the message.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (cnt_q == LAST_RND) begin
          cnt_d   = '0;
          state_d = last_q ? S_FIN : S_WAIT;
        end else begin
          cnt_d = cnt_q + RI_W'(1);
        end
      end
      S_FIN: begin
        if (cnt_q == LAST_RND) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + RI_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d == S_WAIT);
    hs_d   = (state_d == S_INIT);
    vi_d   = (state_d == S_LOAD);
    b_d    = (state_d == S_LOAD) ? byte_d : b_q;
    so_d   = (state_d == S_FIN);
    vrh_d  = (state_d == S_ROUND) || (state_d == S_FIN);
    ri_d   = vrh_d ? cnt_d : '0;
    busy_d = (state_d != S_IDLE);
    dv_d   = (state_d == S_DONE);
  end

  assign bus.in_ready         = rdy_q;
  assign bus.hash_start       = hs_q;
  assign bus.B                = b_q;
  assign bus.validate_input   = vi_q;
  assign bus.switch_operation = so_q;
  assign bus.validate_R_h     = vrh_q;
  assign bus.R_i              = ri_q;
  assign bus.busy             = busy_q;
  assign bus.digest_valid     = dv_q;
  assign bus.error            = err_q;
endmodule

// File: tb/tb_hash_control_unit.sv
// Bench for hash_control_unit: a cycle-timeline model built from the message
// timing rules predicts every output each cycle; directed literals pin it.
module tb_hash_control_unit;
  localparam int unsigned R  = 8;
  localparam int          RN = int'(R);
  localparam int          NC = 6000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hash_control_unit_if bus();

  hash_control_unit #(.ROUNDS(R)) dut (
    .clock (clk),
    .rstn  (rstn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Expected output timeline, indexed by cycle number.
  bit         e_hs[NC], e_vi[NC], e_so[NC], e_vrh[NC], e_dv[NC], e_busy[NC], e_rdy[NC];
  logic [2:0] e_ri[NC];
  bit         b_set[NC], err_set[NC], err_val[NC];
  logic [7:0] b_val[NC];

  bit active;
  int idle_from;
  int wait_from;
  bit accepted;

  logic [7:0]  cur_b   = 8'h00;
  bit          cur_err = 1'b0;
  logic [18:0] exp_v, act_v;

  int n_hs, n_vi, n_rnd, n_fin, n_dv, n_busy, hs_cyc, vi_cyc, dv_cyc;
  logic [7:0] b_seen[$];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void model_reset(input int c, input int idle_c);
    for (int i = c; i < NC; i++) begin
      e_hs[i] = 0; e_vi[i] = 0; e_so[i] = 0; e_vrh[i] = 0; e_dv[i] = 0;
      e_busy[i] = 0; e_rdy[i] = 0; e_ri[i] = 3'd0;
      b_set[i] = 0; err_set[i] = 0; err_val[i] = 0; b_val[i] = 8'h00;
    end
    b_set[c] = 1; b_val[c] = 8'h00;
    err_set[c] = 1; err_val[c] = 1'b0;
    active = 0; wait_from = -1; idle_from = idle_c;
  endfunction

  // Inputs presented during cycle c show up in the outputs from cycle c+1.
  function automatic void model_step(input int c, input bit st, input bit v,
                                     input logic [7:0] d, input bit l, input bit rz);
    accepted = 0;
    if (!active && c >= idle_from) begin
      if (st) begin
        active = 1; e_hs[c+1] = 1;
        err_set[c+1] = 1; err_val[c+1] = 1'b0;
        wait_from = c + 2;
      end
    end else if (active && wait_from >= 0 && c >= wait_from) begin
      e_rdy[c] = 1;
      if (v) begin
        accepted = 1;
        if (!rz) begin
          err_set[c+1] = 1; err_val[c+1] = 1'b1;
          e_dv[c+1] = 1; e_busy[c+1] = 1;
          active = 0; wait_from = -1; idle_from = c + 2;
        end else begin
          e_vi[c+1] = 1; b_set[c+1] = 1; b_val[c+1] = d;
          for (int k = 0; k < RN; k++) begin
            e_vrh[c+2+k] = 1; e_ri[c+2+k] = 3'(k);
          end
          if (l) begin
            for (int k = 0; k < RN; k++) begin
              e_vrh[c+2+RN+k] = 1; e_so[c+2+RN+k] = 1; e_ri[c+2+RN+k] = 3'(k);
            end
            e_dv[c+2+2*RN] = 1;
            for (int t = c + 1; t <= c + 2 + 2*RN; t++) e_busy[t] = 1;
            active = 0; wait_from = -1; idle_from = c + 3 + 2*RN;
          end else begin
            wait_from = c + 2 + RN;
          end
        end
      end
    end
    if (active) e_busy[c+1] = 1;
  endfunction

  // Per-cycle comparison against the model, plus event tallies for directed checks.
  always @(negedge clk) begin
    if (chk_en) begin
      if (b_set[cyc])   cur_b   = b_val[cyc];
      if (err_set[cyc]) cur_err = err_val[cyc];
      exp_v = {e_rdy[cyc], e_hs[cyc], cur_b, e_vi[cyc], e_so[cyc], e_vrh[cyc],
               e_ri[cyc], e_busy[cyc], e_dv[cyc], cur_err};
      act_v = {bus.in_ready, bus.hash_start, bus.B, bus.validate_input,
               bus.switch_operation, bus.validate_R_h, bus.R_i, bus.busy,
               bus.digest_valid, bus.error};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL outputs cycle %0d: got rdy/hs/B/c/e/f/Ri/busy/dv/err=%b/%b/%h/%b/%b/%b/%0d/%b/%b/%b expected %b/%b/%h/%b/%b/%b/%0d/%b/%b/%b",
                 cyc, act_v[18], act_v[17], act_v[16:9], act_v[8], act_v[7], act_v[6],
                 act_v[5:3], act_v[2], act_v[1], act_v[0],
                 exp_v[18], exp_v[17], exp_v[16:9], exp_v[8], exp_v[7], exp_v[6],
                 exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
      end
      if (bus.hash_start === 1'b1) begin n_hs++; hs_cyc = cyc; end
      if (bus.validate_input === 1'b1) begin n_vi++; vi_cyc = cyc; b_seen.push_back(bus.B); end
      if (bus.validate_R_h === 1'b1 && bus.switch_operation === 1'b0) n_rnd++;
      if (bus.validate_R_h === 1'b1 && bus.switch_operation === 1'b1) n_fin++;
      if (bus.digest_valid === 1'b1) begin n_dv++; dv_cyc = cyc; end
      if (bus.busy === 1'b1) n_busy++;
    end
  end

  task automatic clear_obs();
    n_hs = 0; n_vi = 0; n_rnd = 0; n_fin = 0; n_dv = 0; n_busy = 0;
    hs_cyc = -1; vi_cyc = -1; dv_cyc = -1;
    b_seen.delete();
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] d,
                      input bit l, input bit rz);
    if (cyc + 4 + 2*RN >= NC) begin
      $display("FAIL cycle budget: got %0d expected below %0d", cyc, NC - 4 - 2*RN);
      $fatal(1);
    end
    bus.start = st; bus.in_valid = v; bus.in_data = d; bus.in_last = l;
    bus.case_R_c_zero = rz;
    model_step(cyc, st, v, d, l, rz);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_wait();
    int n = 0;
    while (active || cyc < idle_from) begin
      step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
      n++;
      if (n > 300) begin
        chk("idle timeout", n, 0);
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int gap, input bit rz);
    int n = 0;
    repeat (gap) step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
    do begin
      step(1'b0, 1'b1, d, l, rz);
      n++;
    end while (!accepted && n < 100);
    if (!accepted) chk("accept timeout", n, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset(cyc, cyc + 1);
    #1;
    chk("async reset outputs", 32'({bus.in_ready, bus.hash_start, bus.B, bus.validate_input,
        bus.switch_operation, bus.validate_R_h, bus.R_i, bus.busy, bus.digest_valid,
        bus.error}), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc++;
  endtask

  int s, t;

  initial begin
    rstn = 1'b0;
    bus.start = 0; bus.in_valid = 0; bus.in_data = 8'h00; bus.in_last = 0;
    bus.case_R_c_zero = 1;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'({bus.in_ready, bus.hash_start, bus.B, bus.validate_input,
        bus.switch_operation, bus.validate_R_h, bus.R_i, bus.busy, bus.digest_valid,
        bus.error}), 0);
    rstn = 1'b1;
    model_reset(0, 0);
    cyc = 0;
    chk_en = 1'b1;

    // Single byte message.
    step(0, 0, 8'h00, 0, 1);
    clear_obs();
    s = cyc;
    step(1, 0, 8'h00, 0, 1);
    send(8'hA5, 1, 0, 1);
    idle_wait();
    chk("t1 hash_start cycle", hs_cyc - s, 1);
    chk("t1 validate_input cycle", vi_cyc - s, 3);
    chk("t1 digest cycle", dv_cyc - s, 20);
    chk("t1 rounds", n_rnd, 8);
    chk("t1 fin rounds", n_fin, 8);
    chk("t1 busy cycles", n_busy, 20);
    chk("t1 B", (b_seen.size() > 0) ? int'(b_seen[0]) : -1, 8'hA5);

    // Three bytes with gaps.
    clear_obs();
    step(1, 0, 8'h00, 0, 1);
    send(8'h01, 0, 0, 1);
    send(8'h02, 0, 5, 1);
    send(8'h03, 1, 5, 1);
    idle_wait();
    chk("t2 c pulses", n_vi, 3);
    chk("t2 B0", (b_seen.size() > 0) ? int'(b_seen[0]) : -1, 1);
    chk("t2 B1", (b_seen.size() > 1) ? int'(b_seen[1]) : -1, 2);
    chk("t2 B2", (b_seen.size() > 2) ? int'(b_seen[2]) : -1, 3);
    chk("t2 rounds", n_rnd, 24);
    chk("t2 fin rounds", n_fin, 8);
    chk("t2 digests", n_dv, 1);

    // Start pulses while busy are ignored.
    clear_obs();
    step(1, 0, 8'h00, 0, 1);
    send(8'h5A, 1, 0, 1);
    t = cyc - 1;
    for (int i = 0; i <= 2*RN + 1; i++)
      step((i % 3 == 0) || (i == 2*RN + 1), 0, 8'h00, 0, 1);
    idle_wait();
    chk("t3 hash_start count", n_hs, 1);
    chk("t3 digest cycle", dv_cyc - t, 2 + 2*RN);
    chk("t3 error", int'(bus.error), 0);

    // Overflow while a byte is offered.
    clear_obs();
    step(1, 0, 8'h00, 0, 1);
    send(8'hEE, 0, 0, 0);
    t = cyc - 1;
    idle_wait();
    repeat (5) step(0, 0, 8'h00, 0, 1);
    chk("t4 c pulses", n_vi, 0);
    chk("t4 digest cycle", dv_cyc - t, 1);
    chk("t4 sticky error", int'(bus.error), 1);
    step(1, 0, 8'h00, 0, 1);
    chk("t4 error cleared", int'(bus.error), 0);
    send(8'h11, 1, 0, 1);
    idle_wait();

    // Reset in the middle of a round.
    step(1, 0, 8'h00, 0, 1);
    send(8'h99, 0, 0, 1);
    for (int i = 0; i < 20 && !(e_vrh[cyc] && !e_so[cyc] && e_ri[cyc] == 3'd4); i++)
      step(0, 0, 8'h00, 0, 1);
    chk("t5 reached R_i=4", int'(bus.R_i), 4);
    do_reset();
    clear_obs();
    s = cyc;
    step(1, 0, 8'h00, 0, 1);
    send(8'h42, 1, 0, 1);
    idle_wait();
    chk("t5 clean digest cycle", dv_cyc - s, 20);
    chk("t5 clean c pulses", n_vi, 1);

    // Data wiggling while not ready must not reach B.
    clear_obs();
    step(1, 0, 8'h00, 0, 1);
    send(8'h3C, 0, 0, 1);
    for (int i = 0; i <= RN; i++) step(0, 1, 8'($urandom), 0, 1);
    send(8'h77, 1, 0, 1);
    idle_wait();
    chk("t6 c pulses", n_vi, 2);
    chk("t6 B0", (b_seen.size() > 0) ? int'(b_seen[0]) : -1, 8'h3C);
    chk("t6 B1", (b_seen.size() > 1) ? int'(b_seen[1]) : -1, 8'h77);

    // Random traffic.
    while (cyc < NC - 200) begin
      if ($urandom % 600 == 0) do_reset();
      else step(($urandom % 16) == 0, ($urandom % 2) == 1, 8'($urandom),
                ($urandom % 4) == 0, ($urandom % 16) != 0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
